// File: rtl/snapshot_pkg.sv
// Shared state encodings and default geometry for the snapshot sequencer.
package snapshot_pkg;

  localparam int SNAP_DATA_W   = 24;
  localparam int SNAP_DEPTH    = 64;
  localparam int SNAP_TICK_DIV = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/snapshot_ram.sv
// Simple dual-port snapshot store: synchronous write, registered read (block RAM friendly).
module snapshot_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
)(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/snapshot_sequencer.sv
// Records sensor snapshots on a tick timebase and plays them back.
// Define SNAPSHOT_LOOP_EN for continuous looping playback (done pulses at each wrap).
module snapshot_sequencer
  import snapshot_pkg::*;
#(
  parameter int DATA_W   = SNAP_DATA_W,
  parameter int DEPTH    = SNAP_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int TICK_DIV = SNAP_TICK_DIV
)(
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] sensor_in,
  input  logic              save_req,
  input  logic              load_req,
  input  logic              stop_req,
  input  logic              clear_req,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_out
);

  localparam int                TCNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W+1)'(DEPTH);

  state_e            state, state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr, rd_addr_nxt, ram_waddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              in_idle, in_rec, in_play, tick;
  logic              do_clear, do_save, do_load;
  logic              rec_wr, rec_end, rd_wrap, play_show, play_end, done_nxt;

  assign in_idle  = (state == ST_IDLE);
  assign in_rec   = (state == ST_REC);
  assign in_play  = (state == ST_PLAY);
  assign tick     = !in_idle && (tcnt == TCNT_LAST);

  assign do_clear = in_idle && clear_req;
  assign do_save  = in_idle && !clear_req && save_req;
  assign do_load  = in_idle && !clear_req && !save_req && load_req && (count != '0);

  // The final write (count DEPTH-1 -> DEPTH) also ends the recording.
  assign rec_wr   = in_rec && tick && !full;
  assign rec_end  = in_rec && (stop_req || (tick && count >= CNT_MAX - 1'b1));
  assign rd_wrap  = ({1'b0, rd_addr} == count - 1'b1);

`ifdef SNAPSHOT_LOOP_EN
  assign play_show = in_play && tick && !stop_req;
  assign play_end  = 1'b0;
  assign done_nxt  = rec_end || (play_show && rd_wrap);
`else
  // play_last marks that entry count-1 is out; the following tick finishes.
  logic play_last;
  assign play_show = in_play && tick && !stop_req && !play_last;
  assign play_end  = in_play && tick && !stop_req && play_last;
  assign done_nxt  = rec_end || play_end;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (do_save) state_nxt = ST_REC;
               else if (do_load) state_nxt = ST_PLAY;
      ST_REC:  if (rec_end) state_nxt = ST_IDLE;
      ST_PLAY: if (stop_req || play_end) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read address is looked ahead so ram_rdata always holds mem[rd_addr].
  always_comb begin
    busy        = !in_idle;
    state_out   = state;
    full        = (count == CNT_MAX);
    ram_we      = do_save || rec_wr;
    ram_waddr   = in_idle ? '0 : wr_addr;
    rd_addr_nxt = rd_addr;
    if (do_load)        rd_addr_nxt = '0;
    else if (play_show) rd_addr_nxt = rd_wrap ? '0 : rd_addr + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcnt       <= '0;
      count      <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      play_data  <= '0;
      play_valid <= 1'b0;
      done       <= 1'b0;
`ifndef SNAPSHOT_LOOP_EN
      play_last  <= 1'b0;
`endif
    end else begin
      tcnt <= (in_idle || tick || state_nxt != state) ? '0 : tcnt + 1'b1;
      if (do_clear)     count <= '0;
      else if (do_save) count <= (ADDR_W+1)'(1);
      else if (rec_wr)  count <= count + 1'b1;
      if (do_save)      wr_addr <= ADDR_W'(1);
      else if (rec_wr)  wr_addr <= wr_addr + 1'b1;
      rd_addr    <= rd_addr_nxt;
      play_valid <= play_show;
      if (play_show) play_data <= ram_rdata;
      done       <= done_nxt;
`ifndef SNAPSHOT_LOOP_EN
      if (do_load)                 play_last <= 1'b0;
      else if (play_show && rd_wrap) play_last <= 1'b1;
`endif
    end
  end

  snapshot_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (sensor_in),
    .raddr (rd_addr_nxt),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_snapshot_sequencer.sv
// Bench for snapshot_sequencer: directed vector table, corner sequences, randomized model check.
module tb_snapshot_sequencer;

  localparam int DW  = 24;
  localparam int DEP = 4;
  localparam int AW  = 2;
  localparam int TD  = 4;
`ifdef SNAPSHOT_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam logic [23:0] HOLD = LOOP ? 24'h1 : 24'h8;
  localparam logic [3:0] R_SAVE = 4'd1, R_LOAD = 4'd2, R_STOP = 4'd4, R_CLR = 4'd8;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic [DW-1:0] sensor_in = '0;
  logic          save_req = 1'b0, load_req = 1'b0, stop_req = 1'b0, clear_req = 1'b0;
  logic [DW-1:0] play_data;
  logic          play_valid, full, busy, done;
  logic [AW:0]   count;
  logic [1:0]    state_out;

  always #5 clock = ~clock;

  snapshot_sequencer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .TICK_DIV(TD)) dut (
    .clock(clock), .resetn(resetn), .sensor_in(sensor_in),
    .save_req(save_req), .load_req(load_req), .stop_req(stop_req), .clear_req(clear_req),
    .play_data(play_data), .play_valid(play_valid), .count(count), .full(full),
    .busy(busy), .done(done), .state_out(state_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [3:0] rq);
    {clear_req, stop_req, load_req, save_req} = rq;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [23:0] sens;
    int          n;
    logic [1:0]  st;
    logic [2:0]  cnt;
    logic        vld;
    logic        dn;
    logic [23:0] dat;
  } row_t;

  function automatic row_t mk(input logic [3:0] rq, input logic [23:0] s, input int n,
                              input logic [1:0] st, input logic [2:0] cnt,
                              input logic vld, input logic dn, input logic [23:0] d);
    row_t r;
    r.req = rq; r.sens = s; r.n = n; r.st = st; r.cnt = cnt; r.vld = vld; r.dn = dn; r.dat = d;
    return r;
  endfunction

  // Behavioural reference: stored entries as a queue, ticks from cycles spent in the mode.
  int          m_mode;
  int          m_age;
  logic [23:0] m_q[$];
  logic [23:0] m_data;
  logic        m_valid, m_done;

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_q.delete(); m_data = '0; m_valid = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic sv, input logic ld, input logic sp, input logic cl,
                            input logic [23:0] s);
    bit is_tick;
    int idx, k;
    is_tick = (m_age % TD) == TD - 1;
    m_valid = 1'b0;
    m_done  = 1'b0;
    case (m_mode)
      0: begin
        if (cl) m_q.delete();
        else if (sv) begin m_q.delete(); m_q.push_back(s); m_mode = 1; m_age = 0; end
        else if (ld && m_q.size() > 0) begin m_mode = 2; m_age = 0; end
      end
      1: begin
        if (is_tick && m_q.size() < DEP) m_q.push_back(s);
        if (sp || (is_tick && m_q.size() == DEP)) begin m_done = 1'b1; m_mode = 0; end
        else m_age++;
      end
      default: begin
        if (sp) m_mode = 0;
        else begin
          if (is_tick) begin
            idx = (m_age + 1) / TD - 1;
            if (LOOP) begin
              k = idx % m_q.size();
              m_data = m_q[k]; m_valid = 1'b1; m_done = (k == m_q.size() - 1);
            end else if (idx < m_q.size()) begin
              m_data = m_q[idx]; m_valid = 1'b1;
            end else begin
              m_done = 1'b1; m_mode = 0;
            end
          end
          m_age++;
        end
      end
    endcase
  endtask

  row_t tbl[26];

  initial begin
    tbl[0]  = mk(R_SAVE, 24'h1, 1, 2'd1, 3'd1, 0, 0, 24'h0);
    tbl[1]  = mk(4'd0,   24'h2, 4, 2'd1, 3'd2, 0, 0, 24'h0);
    tbl[2]  = mk(4'd0,   24'h4, 4, 2'd1, 3'd3, 0, 0, 24'h0);
    tbl[3]  = mk(4'd0,   24'h8, 3, 2'd1, 3'd3, 0, 0, 24'h0);
    tbl[4]  = mk(4'd0,   24'h8, 1, 2'd0, 3'd4, 0, 1, 24'h0);
    tbl[5]  = mk(4'd0,   24'h8, 1, 2'd0, 3'd4, 0, 0, 24'h0);
    tbl[6]  = mk(R_LOAD, 24'h8, 1, 2'd2, 3'd4, 0, 0, 24'h0);
    tbl[7]  = mk(4'd0,   24'h8, 3, 2'd2, 3'd4, 0, 0, 24'h0);
    tbl[8]  = mk(4'd0,   24'h8, 1, 2'd2, 3'd4, 1, 0, 24'h1);
    tbl[9]  = mk(4'd0,   24'h8, 4, 2'd2, 3'd4, 1, 0, 24'h2);
    tbl[10] = mk(4'd0,   24'h8, 4, 2'd2, 3'd4, 1, 0, 24'h4);
    tbl[11] = mk(4'd0,   24'h8, 4, 2'd2, 3'd4, 1, LOOP, 24'h8);
    tbl[12] = mk(4'd0,   24'h8, 3, 2'd2, 3'd4, 0, 0, 24'h8);
    if (LOOP) begin
      tbl[13] = mk(4'd0,   24'h8, 1, 2'd2, 3'd4, 1, 0, 24'h1);
      tbl[14] = mk(R_STOP, 24'h8, 1, 2'd0, 3'd4, 0, 0, 24'h1);
    end else begin
      tbl[13] = mk(4'd0,   24'h8, 1, 2'd0, 3'd4, 0, 1, 24'h8);
      tbl[14] = mk(4'd0,   24'h8, 1, 2'd0, 3'd4, 0, 0, 24'h8);
    end
    tbl[15] = mk(R_CLR | R_SAVE, 24'h8, 1, 2'd0, 3'd0, 0, 0, HOLD);
    tbl[16] = mk(R_LOAD, 24'h8,  1, 2'd0, 3'd0, 0, 0, HOLD);
    tbl[17] = mk(4'd0,   24'h8,  4, 2'd0, 3'd0, 0, 0, HOLD);
    tbl[18] = mk(R_SAVE, 24'h11, 1, 2'd1, 3'd1, 0, 0, HOLD);
    tbl[19] = mk(4'd0,   24'h22, 4, 2'd1, 3'd2, 0, 0, HOLD);
    tbl[20] = mk(R_STOP, 24'h33, 1, 2'd0, 3'd2, 0, 1, HOLD);
    tbl[21] = mk(4'd0,   24'h33, 1, 2'd0, 3'd2, 0, 0, HOLD);
    tbl[22] = mk(R_LOAD, 24'h33, 1, 2'd2, 3'd2, 0, 0, HOLD);
    tbl[23] = mk(4'd0,   24'h33, 4, 2'd2, 3'd2, 1, 0, 24'h11);
    tbl[24] = mk(R_STOP, 24'h33, 1, 2'd0, 3'd2, 0, 0, 24'h11);
    tbl[25] = mk(4'd0,   24'h33, 3, 2'd0, 3'd2, 0, 0, 24'h11);

    // power-on reset
    #1 resetn = 1'b0;
    #2;
    chk("reset state", state_out, 0);
    chk("reset count", count, 0);
    chk("reset data", play_data, 0);
    chk("reset valid", play_valid, 0);
    chk("reset done", done, 0);
    chk("reset full", full, 0);
    chk("reset busy", busy, 0);
    step(); step();
    resetn = 1'b1;

    // directed vector table
    for (int i = 0; i < 26; i++) begin
      sensor_in = tbl[i].sens;
      set_req(tbl[i].req);
      for (int c = 0; c < tbl[i].n; c++) begin
        step();
        set_req(4'd0);
      end
      chk($sformatf("row%0d state", i), state_out, tbl[i].st);
      chk($sformatf("row%0d count", i), count, tbl[i].cnt);
      chk($sformatf("row%0d valid", i), play_valid, tbl[i].vld);
      chk($sformatf("row%0d done", i), done, tbl[i].dn);
      chk($sformatf("row%0d data", i), play_data, tbl[i].dat);
      chk($sformatf("row%0d full", i), full, tbl[i].cnt == 3'd4);
      chk($sformatf("row%0d busy", i), busy, tbl[i].st != 2'd0);
    end

    // asynchronous reset in the middle of a recording
    sensor_in = 24'h55;
    set_req(R_SAVE);
    step();
    set_req(4'd0);
    for (int c = 0; c < 5; c++) step();
    chk("midrec pre state", state_out, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrec state", state_out, 0);
    chk("midrec count", count, 0);
    chk("midrec data", play_data, 0);
    chk("midrec valid", play_valid, 0);
    chk("midrec done", done, 0);
    chk("midrec busy", busy, 0);
    step(); step();
    resetn = 1'b1;

`ifdef SNAPSHOT_LOOP_EN
    // looping playback over two entries
    begin
      int waited;
      sensor_in = 24'h1; set_req(R_SAVE); step(); set_req(4'd0);
      sensor_in = 24'h2;
      for (int c = 0; c < 4; c++) step();
      set_req(R_STOP); step(); set_req(4'd0);
      chk("loop count", count, 2);
      set_req(R_LOAD); step(); set_req(4'd0);
      for (int k = 0; k < 6; k++) begin
        waited = 0;
        while (!play_valid && waited < 2 * TD) begin step(); waited++; end
        chk($sformatf("loop%0d seen", k), play_valid, 1);
        chk($sformatf("loop%0d data", k), play_data, (k % 2 == 0) ? 1 : 2);
        chk($sformatf("loop%0d done", k), done, k % 2);
        if (play_valid) step();
      end
      set_req(R_STOP); step(); set_req(4'd0);
      chk("loop exit state", state_out, 0);
      chk("loop exit done", done, 0);
    end
`endif

    // randomized run against the reference model
    #2 resetn = 1'b0;
    step();
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic sv, ld, sp, cl;
      sv = ($urandom_range(0, 11) == 0);
      ld = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 29) == 0);
      sensor_in = DW'($urandom);
      {save_req, load_req, stop_req, clear_req} = {sv, ld, sp, cl};
      model_step(sv, ld, sp, cl, sensor_in);
      step();
      chk($sformatf("rnd%0d state", c), state_out, m_mode);
      chk($sformatf("rnd%0d count", c), count, m_q.size());
      chk($sformatf("rnd%0d valid", c), play_valid, m_valid);
      chk($sformatf("rnd%0d done", c), done, m_done);
      chk($sformatf("rnd%0d data", c), play_data, m_data);
      chk($sformatf("rnd%0d full", c), full, m_q.size() == DEP);
      chk($sformatf("rnd%0d busy", c), busy, m_mode != 0);
    end
    set_req(4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
